// File: rtl/snes_pkg.sv
// ---------------------------------------------------------------------------
// snes_pkg : shared states, 25 MHz timing defaults, SNES button bit indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // 6 us pad half period and idle gap at 25 MHz
    localparam int c_half_cyc_25m = 150;
    localparam int c_gap_cyc_25m  = 2000;

    localparam int c_btn_b      = 0;
    localparam int c_btn_y      = 1;
    localparam int c_btn_select = 2;
    localparam int c_btn_start  = 3;
    localparam int c_btn_up     = 4;
    localparam int c_btn_down   = 5;
    localparam int c_btn_left   = 6;
    localparam int c_btn_right  = 7;
    localparam int c_btn_a      = 8;
    localparam int c_btn_x      = 9;
    localparam int c_btn_l      = 10;
    localparam int c_btn_r      = 11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snes_pad_sync.sv
// ---------------------------------------------------------------------------
// snes_pad_sync : WIDTH-wide two-flop synchroniser, resets to 1 (released)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snes_pad_sync
    import snes_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

endmodule

`default_nettype wire

// File: rtl/snes_pad_scanner.sv
// ---------------------------------------------------------------------------
// snes_pad_scanner : multi-pad SNES/NES serial scanner, latch/clock generator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snes_pad_scanner
    import snes_pkg::*;
#(
    parameter int NUM_PADS  = 2,
    parameter int NUM_BITS  = 16,
    parameter int HALF_CYC  = c_half_cyc_25m,
    parameter int GAP_CYC   = c_gap_cyc_25m,
    parameter bit AUTO_POLL = 1'b1
) (
    input  logic                         clk_25M,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         start,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         frame_valid,
    output logic                         frame_changed,
    output logic                         busy
);

    localparam int TMR_W = $clog2(max_int(2 * HALF_CYC, GAP_CYC) + 1);
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [TMR_W-1:0] c_tmr_latch = TMR_W'(2 * HALF_CYC - 1);
    localparam logic [TMR_W-1:0] c_tmr_half  = TMR_W'(HALF_CYC - 1);
    localparam logic [TMR_W-1:0] c_tmr_gap   = TMR_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_BITS - 1);

    state_t                              r_state;
    state_t                              w_next;
    logic   [TMR_W-1:0]                  r_tmr;
    logic   [TMR_W-1:0]                  w_load_val;
    logic                                w_load;
    logic                                w_commit;
    logic                                w_tmr_done;
    logic   [IDX_W-1:0]                  r_idx;
    logic   [NUM_PADS-1:0]               w_sync;
    logic   [NUM_PADS-1:0][NUM_BITS-1:0] r_shadow;
    logic   [NUM_PADS*NUM_BITS-1:0]      w_new;
    logic   [NUM_PADS*NUM_BITS-1:0]      r_buttons;
    logic                                r_latch;
    logic                                r_clk;
    logic                                r_busy;
    logic                                r_valid;
    logic                                r_changed;

    snes_pad_sync #(
        .WIDTH (NUM_PADS)
    ) u_sync (
        .clk  (clk_25M),
        .rst  (rst),
        .din  (pad_data),
        .dout (w_sync)
    );

    assign w_tmr_done = (r_tmr == '0);
    assign w_new      = ~r_shadow;

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_commit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((AUTO_POLL && enable) || (!AUTO_POLL && start)) begin
                    w_next     = ST_LATCH;
                    w_load     = 1'b1;
                    w_load_val = c_tmr_latch;
                end
            end
            ST_LATCH, ST_LOW: begin
                if (w_tmr_done) begin
                    w_next     = (r_state == ST_LATCH) ? ST_LOW : ST_HIGH;
                    w_load     = 1'b1;
                    w_load_val = c_tmr_half;
                end
            end
            ST_HIGH: begin
                if (w_tmr_done) begin
                    if (r_idx == c_idx_last) begin
                        w_commit = 1'b1;
                        if (AUTO_POLL) begin
                            w_next     = ST_GAP;
                            w_load     = 1'b1;
                            w_load_val = c_tmr_gap;
                        end else begin
                            w_next = ST_IDLE;
                        end
                    end else begin
                        w_next     = ST_LOW;
                        w_load     = 1'b1;
                        w_load_val = c_tmr_half;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_done) begin
                    if (enable) begin
                        w_next     = ST_LATCH;
                        w_load     = 1'b1;
                        w_load_val = c_tmr_latch;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Timer, bit index and per-pad shadow capture
    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_tmr    <= '0;
            r_idx    <= '0;
            r_shadow <= '1;
        end else begin
            if (w_load) begin
                r_tmr <= w_load_val;
            end else if (!w_tmr_done) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (r_state == ST_LATCH) begin
                r_idx <= '0;
            end else if (r_state == ST_HIGH && w_tmr_done && !w_commit) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_LOW && w_tmr_done) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    r_shadow[p][r_idx] <= w_sync[p];
                end
            end
        end
    end

    // Pin levels follow the next state so they change on the entering edge
    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_latch   <= 1'b0;
            r_clk     <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_buttons <= '0;
        end else begin
            r_latch   <= (w_next == ST_LATCH);
            r_clk     <= (w_next != ST_LOW);
            r_busy    <= (w_next == ST_LATCH) || (w_next == ST_LOW) || (w_next == ST_HIGH);
            r_valid   <= w_commit;
            r_changed <= w_commit && (w_new != r_buttons);
            if (w_commit) begin
                r_buttons <= w_new;
            end
        end
    end

    assign pad_latch     = r_latch;
    assign pad_clk       = r_clk;
    assign busy          = r_busy;
    assign frame_valid   = r_valid;
    assign frame_changed = r_changed;
    assign buttons       = r_buttons;

endmodule

`default_nettype wire
